// File: rtl/addsub_serial.sv
// ---------------------------------------------------------------------------
// addsub_serial
//   Multi-cycle two's-complement adder/subtractor. Operands are accepted on a
//   valid/ready handshake, summed DIGIT bits per clock over N = WIDTH/DIGIT
//   cycles, and the result plus flags are offered on a second valid/ready
//   handshake.
//
// Parameters
//   WIDTH  operand/result width (>= 1)
//   DIGIT  bits summed per clock; WIDTH must be a multiple of DIGIT
//
// Ports
//   clk, rst_n           clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake (A, B, op; op=1 selects A-B)
//   abort                synchronous cancel, returns to IDLE next edge
//   out_valid/out_ready  result handshake (S, carry, overflow, zero, negative)
//
// Optional feature
//   ADDSUB_SAT_EN  when defined, a signed overflow clamps S to the signed
//                  limit in the overflow direction; carry stays raw.
// ---------------------------------------------------------------------------
module addsub_serial #(
  parameter int WIDTH = 32,
  parameter int DIGIT = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             op,
  input  logic             abort,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] S,
  output logic             carry,
  output logic             overflow,
  output logic             zero,
  output logic             negative
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;

  if ((WIDTH < 1) || (DIGIT < 1) || ((WIDTH % DIGIT) != 0)) begin : g_bad_params
    $error("addsub_serial: WIDTH must be >= 1 and a multiple of DIGIT");
  end

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q;
  logic [WIDTH-1:0] a_q, b_q;     // operands, shifted right one digit per RUN cycle
  logic [WIDTH-1:0] acc_q;        // partial sums shifted in from the top
  logic             carry_q;
  logic [CW-1:0]    cnt_q;
  logic             in_ready_q, out_valid_q;
  logic [WIDTH-1:0] s_q;
  logic             carry_o_q, ovf_q, zero_q, neg_q;

  // Current digit always sits in the low DIGIT bits of a_q/b_q.
  logic [DIGIT:0]   dsum;
  logic [WIDTH-1:0] res_full;
  logic [WIDTH-1:0] s_fin;
  logic             cin_msb, ovf_fin;

  assign dsum = {1'b0, a_q[DIGIT-1:0]} + {1'b0, b_q[DIGIT-1:0]} + {{DIGIT{1'b0}}, carry_q};

  // New digit enters at the top; after N cycles the word is in natural order.
  if (N == 1) begin : g_single
    assign res_full = dsum[DIGIT-1:0];
  end else begin : g_multi
    assign res_full = {dsum[DIGIT-1:0], acc_q[WIDTH-1:DIGIT]};
  end

  // Carry into the MSB recovered from the MSB sum bit and its two inputs.
  assign cin_msb = res_full[WIDTH-1] ^ a_q[DIGIT-1] ^ b_q[DIGIT-1];
  assign ovf_fin = dsum[DIGIT] ^ cin_msb;

  always_comb begin
    s_fin = res_full;
`ifdef ADDSUB_SAT_EN
    if (ovf_fin) begin
      // Raw sign 1 means positive overflow -> 0111..1; sign 0 -> 1000..0.
      s_fin            = {WIDTH{res_full[WIDTH-1]}};
      s_fin[WIDTH-1]   = ~res_full[WIDTH-1];
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      s_q         <= '0;
      carry_o_q   <= 1'b0;
      ovf_q       <= 1'b0;
      zero_q      <= 1'b0;
      neg_q       <= 1'b0;
    end else if (abort) begin
      // Results and flags keep their last values; only the handshake resets.
      state_q     <= IDLE;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            a_q        <= A;
            b_q        <= B ^ {WIDTH{op}};
            carry_q    <= op;
            cnt_q      <= '0;
            state_q    <= RUN;
            in_ready_q <= 1'b0;
          end
        end
        RUN: begin
          a_q     <= a_q >> DIGIT;
          b_q     <= b_q >> DIGIT;
          acc_q   <= res_full;
          carry_q <= dsum[DIGIT];
          cnt_q   <= cnt_q + CW'(1);
          if (cnt_q == CW'(N - 1)) begin
            s_q         <= s_fin;
            carry_o_q   <= dsum[DIGIT];
            ovf_q       <= ovf_fin;
            zero_q      <= (s_fin == '0);
            neg_q       <= s_fin[WIDTH-1];
            state_q     <= DONE;
            out_valid_q <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_q     <= IDLE;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
          end
        end
        default: begin
          state_q     <= IDLE;
          in_ready_q  <= 1'b1;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign S         = s_q;
  assign carry     = carry_o_q;
  assign overflow  = ovf_q;
  assign zero      = zero_q;
  assign negative  = neg_q;

endmodule

// File: tb/tb_addsub_serial.sv
module tb_addsub_serial;
  localparam int NC = 4;

`ifdef ADDSUB_SAT_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // 32-bit / 8-digit instance
  logic        in_valid = 1'b0, abort = 1'b0, out_ready = 1'b1, op = 1'b0;
  logic [31:0] a = '0, b = '0;
  logic        in_ready, out_valid, carry, overflow, zero, negative;
  logic [31:0] s;

  addsub_serial #(.WIDTH(32), .DIGIT(8)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .A(a), .B(b), .op(op), .abort(abort), .out_valid(out_valid),
    .out_ready(out_ready), .S(s), .carry(carry), .overflow(overflow),
    .zero(zero), .negative(negative)
  );

  // 8-bit single-digit instance
  logic       in_valid8 = 1'b0, op8 = 1'b0, abort8 = 1'b0, out_ready8 = 1'b1;
  logic [7:0] a8 = '0, b8 = '0;
  logic       in_ready8, out_valid8, carry8, overflow8, zero8, negative8;
  logic [7:0] s8;

  addsub_serial #(.WIDTH(8), .DIGIT(8)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
    .A(a8), .B(b8), .op(op8), .abort(abort8), .out_valid(out_valid8),
    .out_ready(out_ready8), .S(s8), .carry(carry8), .overflow(overflow8),
    .zero(zero8), .negative(negative8)
  );

  int checks = 0;
  int errors = 0;
  logic [35:0] q32[$];
  logic [11:0] q8[$];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end else begin
      $display("ok   %s value=%h", name, got);
    end
  endtask

  // Scoreboard monitors: compare whenever a result handshake is presented.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (q32.size() == 0) begin
        checks++; errors++;
        $display("FAIL result32 unexpected got=%h", {s, carry, overflow, zero, negative});
      end else begin
        check("result32", {28'b0, s, carry, overflow, zero, negative}, {28'b0, q32.pop_front()});
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && out_valid8 && out_ready8) begin
      if (q8.size() == 0) begin
        checks++; errors++;
        $display("FAIL result8 unexpected got=%h", {s8, carry8, overflow8, zero8, negative8});
      end else begin
        check("result8", {52'b0, s8, carry8, overflow8, zero8, negative8}, {52'b0, q8.pop_front()});
      end
    end
  end

  // Expected = {S, carry, overflow, zero, negative}
  task automatic send32(input logic [31:0] ta, input logic [31:0] tb_v, input logic top,
                        input logic [35:0] e, input int hold);
    int n;
    a = ta; b = tb_v; op = top;
    if (hold > 0) out_ready = 1'b0;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    check("accept32", {63'b0, in_ready}, 64'd1);
    q32.push_back(e);
    @(posedge clk); #1;
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("latency32", 64'(n), 64'(NC));
    for (int i = 0; i < hold; i++) begin
      check("hold32", {26'b0, s, carry, overflow, zero, negative, in_ready, out_valid}, {26'b0, e, 2'b01});
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    n = 0;
    while (out_valid && n < 50) begin @(posedge clk); #1; n++; end
    check("release32", {63'b0, out_valid}, 64'd0);
  endtask

  task automatic send8(input logic [7:0] ta, input logic [7:0] tb_v, input logic top,
                       input logic [11:0] e);
    int n;
    a8 = ta; b8 = tb_v; op8 = top; in_valid8 = 1'b1;
    n = 0;
    while (!in_ready8 && n < 50) begin @(posedge clk); #1; n++; end
    q8.push_back(e);
    @(posedge clk); #1;
    in_valid8 = 1'b0;
    n = 0;
    while (!out_valid8 && n < 50) begin @(posedge clk); #1; n++; end
    check("latency8", 64'(n), 64'd1);
    n = 0;
    while (out_valid8 && n < 50) begin @(posedge clk); #1; n++; end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    repeat (2) @(posedge clk);
    #1;
    check("reset32", {26'b0, s, carry, overflow, zero, negative, in_ready, out_valid}, {26'b0, 36'b0, 2'b10});
    check("reset8", {54'b0, s8, carry8, overflow8, zero8, negative8, in_ready8, out_valid8}, {54'b0, 12'b0, 2'b10});
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;

    // Positive overflow
    send32(32'h7FFF_FFFF, 32'h1, 1'b0,
           SAT ? {32'h7FFF_FFFF, 4'b0100} : {32'h8000_0000, 4'b0101}, 0);
    // Small subtract going negative
    send32(32'd5, 32'd7, 1'b1, {32'hFFFF_FFFE, 4'b0001}, 0);

    // Asynchronous reset in the middle of RUN
    a = 32'h1111_1111; b = 32'h2222_2222; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1;
    #2 rst_n = 1'b0; #1;
    check("rst_mid_run", {26'b0, s, carry, overflow, zero, negative, in_ready, out_valid}, {26'b0, 36'b0, 2'b10});
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check("rst_in_ready", {63'b0, in_ready}, 64'd1);

    // Equal operands subtract, with output back-pressure
    send32(32'h1234_5678, 32'h1234_5678, 1'b1, {32'h0, 4'b1010}, 10);
    // Carry across a digit boundary
    send32(32'h0000_00FF, 32'h1, 1'b0, {32'h0000_0100, 4'b0000}, 0);
    send32(32'h0000_1234, 32'h0000_5678, 1'b0, {32'h0000_68AC, 4'b0000}, 0);

    // Abort during RUN: back to IDLE, no result, S keeps its last value
    a = 32'h1; b = 32'h1; op = 1'b0; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    @(posedge clk); #1; abort = 1'b1;
    @(posedge clk); #1; abort = 1'b0;
    check("abort_idle", {62'b0, in_ready, out_valid}, 64'b10);
    n = 0;
    repeat (NC + 3) begin
      if (out_valid) n++;
      @(posedge clk); #1;
    end
    check("abort_no_valid", 64'(n), 64'd0);
    check("abort_hold_S", {28'b0, s, carry, overflow, zero, negative}, {28'b0, 32'h0000_68AC, 4'b0000});

    // Abort in IDLE blocks capture
    a = 32'h5; b = 32'h5; in_valid = 1'b1; abort = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; abort = 1'b0;
    check("abort_idle_block", {63'b0, in_ready}, 64'd1);

    // Wrap-around and overflow boundaries
    send32(32'hFFFF_FFFF, 32'h1, 1'b0, {32'h0, 4'b1010}, 0);
    send32(32'h8000_0000, 32'h1, 1'b1,
           SAT ? {32'h8000_0000, 4'b1101} : {32'h7FFF_FFFF, 4'b1100}, 0);
    send32(32'h8000_0000, 32'h8000_0000, 1'b0,
           SAT ? {32'h8000_0000, 4'b1101} : {32'h0, 4'b1110}, 0);

    // Single-digit instance
    send8(8'h80, 8'h01, 1'b1, SAT ? {8'h80, 4'b1101} : {8'h7F, 4'b1100});
    send8(8'h10, 8'h20, 1'b0, {8'h30, 4'b0000});
    send8(8'hFF, 8'hFF, 1'b0, {8'hFE, 4'b1001});

    repeat (3) @(posedge clk);
    #1;
    check("queues_empty", 64'(q32.size() + q8.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
